// File: rtl/seven_seg_scan_if.sv
// rtl/seven_seg_scan_if.sv - frame-load and display bus for the seven-segment scan controller
interface seven_seg_scan_if;
    logic [27:0] seg_in;
    logic        load;
    logic        ready;
    logic [6:0]  seg_out;
    logic [3:0]  an_n;
    logic        frame_done;

    modport master (
        output seg_in,
        output load,
        input  ready,
        input  seg_out,
        input  an_n,
        input  frame_done
    );

    modport slave (
        input  seg_in,
        input  load,
        output ready,
        output seg_out,
        output an_n,
        output frame_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - 4-digit multiplexed seven-segment scanner with double-buffered frames
// Optional anti-ghosting dead time per slot: define SEVEN_SEG_BLANK_EN.
module seven_seg_scan_ctrl #(
    parameter int DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    seven_seg_scan_if.slave   bus
);
    localparam logic [15:0] LAST = 16'(DIV - 1);

    typedef enum logic {BLANK, SCAN} state_t;

`ifdef SEVEN_SEG_BLANK_EN
    localparam state_t RESET_STATE = BLANK;
`else
    localparam state_t RESET_STATE = SCAN;
`endif

    logic [15:0] cnt, cnt_nxt;
    logic [1:0]  idx;
    logic        tick;
    logic        frame_done;
    state_t      state, state_nxt;
    logic [27:0] active, shadow;
    logic        full;
    logic [6:0]  digit;
    logic [6:0]  seg_out;
    logic [3:0]  an_n;

    assign tick       = (cnt == LAST);
    assign cnt_nxt    = tick ? 16'd0 : cnt + 16'd1;
    assign frame_done = tick && (idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 16'd0;
            idx   <= 2'd0;
            state <= RESET_STATE;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
            if (tick)
                idx <= idx + 2'd1;
        end
    end

    // State is registered from the upcoming count so it lines up with cnt without lag.
    always_comb begin
        state_nxt = SCAN;
`ifdef SEVEN_SEG_BLANK_EN
        if (cnt_nxt < 16'd2)
            state_nxt = BLANK;
`endif
    end

    always_comb begin
        digit = 7'd0;
        case (idx)
            2'd0: digit = active[6:0];
            2'd1: digit = active[13:7];
            2'd2: digit = active[20:14];
            2'd3: digit = active[27:21];
            default: digit = 7'd0;
        endcase
    end

    always_comb begin
        an_n    = 4'b1111;
        seg_out = 7'd0;
        case (state)
            SCAN: begin
                an_n    = ~(4'b0001 << idx);
                seg_out = digit;
            end
            default: begin
                an_n    = 4'b1111;
                seg_out = 7'd0;
            end
        endcase
    end

    // Active only changes on a frame boundary; a load on that same edge waits for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 28'd0;
            shadow <= 28'd0;
            full   <= 1'b0;
        end else if (frame_done && full) begin
            active <= shadow;
            full   <= 1'b0;
        end else if (bus.load && !full) begin
            shadow <= bus.seg_in;
            full   <= 1'b1;
        end
    end

    assign bus.ready      = ~full;
    assign bus.seg_out    = seg_out;
    assign bus.an_n       = an_n;
    assign bus.frame_done = frame_done;
endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter: DIV, default 50000, clock cycles per digit slot; legal range 4..65535.
REQ-002 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: seg_in  input  28  new frame of segment patterns; bits [7k+6:7k] are digit k (k=0..3); digit 3 carries the sign pattern.
REQ-005 Port: load  input  1  frame-write request, sampled every clk edge.
REQ-006 Port: ready  output  1  high when the shadow register is empty and a load is accepted.
REQ-007 Port: seg_out  output  7  segment lines shared by all digits, active-high.
REQ-008 Port: an_n  output  4  digit enables, active-low, one-hot-low or all-high.
REQ-009 Port: frame_done  output  1  one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-010 The prescaler cnt SHALL count 0..DIV-1 and wrap to 0; tick is asserted when cnt==DIV-1.
REQ-011 The digit index idx (2 bits) SHALL advance by 1 on tick and wrap 3->0.
REQ-012 The FSM SHALL have states BLANK and SCAN; the state is SCAN whenever cnt>=2 and BLANK whenever cnt<2 (BLANK reachable only under BLANK_EN, see REQ-024).
REQ-013 In SCAN, an_n SHALL equal ~(4'b0001<<idx) and seg_out SHALL equal active digit idx, with no cycle of latency after idx/cnt change.
REQ-014 In BLANK, an_n SHALL be 4'b1111 and seg_out SHALL be 7'b0000000.
REQ-015 frame_done SHALL be high for exactly the cycle in which tick is asserted with idx==3.
REQ-016 A load while ready==1 SHALL capture seg_in into the shadow register and drive ready low on the next cycle.
REQ-017 A load while ready==0 SHALL be ignored; the shadow register is unchanged.
REQ-018 On the frame_done cycle with the shadow full, the active register SHALL take the shadow contents and ready SHALL return high on the next cycle; display content changes only at frame boundaries (no tearing).
REQ-019 A load accepted in the same cycle as frame_done SHALL fill the shadow but SHALL NOT be transferred until the following frame_done.
REQ-020 On a frame_done with the shadow empty, the active register SHALL be retained.

Reset
REQ-021 Asserting rst_n low SHALL immediately, without a clock, force cnt=0, idx=0, active=all zeros, shadow empty, ready=1, frame_done=0.
REQ-022 On reset, seg_out SHALL be 7'b0000000 and an_n SHALL be 4'b1110 (BLANK_EN undefined) or 4'b1111 (BLANK_EN defined).
REQ-023 Reset asserted mid-frame SHALL discard any pending shadow frame; scanning restarts at digit 0, cnt 0, after release.

Configuration
REQ-024 Macro SEVEN_SEG_BLANK_EN defined: the first 2 cycles (cnt 0 and 1) of every slot SHALL be BLANK, giving anti-ghosting dead time; remaining DIV-2 cycles SCAN.
REQ-025 Macro SEVEN_SEG_BLANK_EN undefined: the FSM SHALL remain in SCAN for all DIV cycles of every slot; BLANK logic is not compiled.

Verification (DIV=4)
REQ-026 Reset release, no load, 20 cycles -> an_n sequence 1110,1101,1011,0111 each held 4 cycles (no BLANK_EN), seg_out 0, frame_done pulse at cycle 15.
REQ-027 load with seg_in=28'h0000001 (digit 0 = 7'b0000001) mid-frame -> ready low next cycle; seg_out stays 0 until first frame_done, then 7'b0000001 during idx 0; ready high after transfer.
REQ-028 Second load while ready==0 with seg_in=28'hFFFFFFF -> ignored; displayed data equals first frame after transfer.
REQ-029 load coincident with frame_done -> shadow filled, active unchanged at that boundary, transferred at next frame_done.
REQ-030 BLANK_EN defined -> in each slot an_n=1111 and seg_out=0 for cnt 0..1, digit driven for cnt 2..3.
REQ-031 rst_n pulsed low mid-slot with shadow full -> outputs immediately at reset values, ready=1, old frame never displayed.
